spi_dc_frame_ctrl: RTL
======================

# spi_dc_frame_ctrl

Frame controller placed directly behind the SPI slave receiver in the AXI SPI DC slave IP. It gates the receiver's enable with chip select and classifies each received word as command or parameter using the sampled D/C line. It decodes write commands into a sequence of register-bank write strobes and reports framing errors: wrong D/C, short frame on chip-select release, and inter-word timeout.

## Interface
- DATA_LEN, 8: received word width; must be 8.
- ADDR_W, 4: register-bank address width; addresses wrap modulo 2^ADDR_W.
- TIMEOUT, 1000: maximum clk cycles between parameter words; range 2..65535.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cs_n  in  1  chip select, active-low, already synchronized to clk upstream.
- dc  in  1  data/command, synchronized to clk; 0 = command, 1 = parameter; sampled when rx_qvld=1.
- rx_qvld  in  1  one-cycle pulse from the receiver; rx_dout is valid.
- rx_dout  in  DATA_LEN  received word.
- rx_en  out  1  receiver enable.
- cmd_valid  out  1  one-cycle pulse when a command word is accepted.
- cmd  out  DATA_LEN  last accepted command word; held until the next one.
- reg_we  out  1  one-cycle register write strobe.
- reg_addr  out  ADDR_W  write address.
- reg_wdata  out  DATA_LEN  write data.
- busy  out  1  high while a write command is awaiting parameters.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  2  cause of last error: 1 = dc=1 while expecting a command, 2 = new command before parameters complete, 3 = timeout or cs_n release with parameters pending; held until the next error.

## Operation
- Command word format: cmd[7] = write flag; cmd[6:4] = parameter count - 1 (1..8); cmd[3:ADDR_W-? ] low ADDR_W bits = start address.
- States:
  - IDLE: entered on reset. rx_en=0. Goes to WAIT_CMD when cs_n=0.
  - WAIT_CMD: rx_en=1. A word with dc=0 is latched into cmd and pulses cmd_valid. If cmd[7]=1, load addr_ptr = start address and remaining = cmd[6:4]+1, then go to WAIT_DATA. If cmd[7]=0, stay in WAIT_CMD. A word with dc=1 is discarded, frame_err pulses, err_code=1.
  - WAIT_DATA: rx_en=1, busy=1. A word with dc=1 drives reg_we with reg_addr=addr_ptr and reg_wdata=word; addr_ptr increments with wrap, remaining decrements, and the block returns to WAIT_CMD when remaining reaches 0. A word with dc=0 pulses frame_err with err_code=2 and is processed as a new command, as in WAIT_CMD, in the same cycle.
- Timeout counter: cleared on entry to WAIT_DATA and on every accepted word. When it reaches TIMEOUT, frame_err pulses with err_code=3 and the block goes to WAIT_CMD.
- cs_n=1 in any non-IDLE state: go to IDLE on the next clock. If in WAIT_DATA, frame_err pulses with err_code=3.
- cs_n=1 coinciding with rx_qvld: cs_n wins; the word is dropped.
- Timeout coinciding with rx_qvld: the word wins; the counter is cleared.

## Timing
- All outputs are registered.
- rx_qvld at cycle N produces cmd_valid, reg_we and frame_err at cycle N+1.
- rx_en drops 1 cycle after cs_n rises.
- Back-to-back rx_qvld on consecutive cycles must be handled; each produces one strobe.
- Reset values: rx_en=0, cmd_valid=0, cmd=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, frame_err=0, err_code=0; state=IDLE, counters 0.
- Asserting rst mid-frame aborts the frame with no strobe or error pulse.

## Structure
- Shared package holds: state encoding (IDLE, WAIT_CMD, WAIT_DATA); err_code constants; command field positions (write-flag bit, count field [6:4]).
- Natural sub-module: spi_dc_timeout_cnt, a loadable counter with clear input and expiry pulse.

## Test plan
- cs_n=0; command 0x93 (write, 2 params, address 3); params 0xAA, 0x55 -> cmd_valid once; reg_we at addr 3 with 0xAA and at addr 4 with 0x55; busy falls after the second write.
- Command 0xFE (8 params from address 14) -> writes to addresses 14, 15, 0, 1, …, 5 (wrap).
- Parameter word 0x11 with dc=1 in WAIT_CMD -> frame_err with err_code=1; no reg_we.
- Command 0x90, then a dc=0 word 0x05 before any parameter -> frame_err with err_code=2; cmd=0x05; cmd_valid pulses; no reg_we.
- Command 0x90 then no parameter for TIMEOUT cycles -> frame_err with err_code=3, busy=0. Separately, cs_n rising mid-parameters -> err_code=3, rx_en=0 one cycle later.
- rst asserted during WAIT_DATA -> all outputs reset immediately; the next frame decodes correctly.

Source files
------------

// File: rtl/spi_dc_frame_ctrl_pkg.sv
// Shared definitions for the SPI D/C frame controller: state encoding,
// error codes and command-word field positions.
package spi_dc_frame_ctrl_pkg;

  localparam int unsigned CMD_W       = 8;
  localparam int unsigned CMD_WR_BIT  = 7;
  localparam int unsigned CMD_CNT_MSB = 6;
  localparam int unsigned CMD_CNT_LSB = 4;
  localparam int unsigned REM_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_CMD  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_DC        = 2'd1;
  localparam logic [1:0] ERR_EARLY_CMD = 2'd2;
  localparam logic [1:0] ERR_ABORT     = 2'd3;

  // Number of parameter words a write command expects (1..8).
  function automatic logic [REM_W-1:0] param_count(input logic [CMD_W-1:0] word);
    return REM_W'(word[CMD_CNT_MSB:CMD_CNT_LSB]) + REM_W'(1);
  endfunction

endpackage

// File: rtl/spi_dc_timeout_cnt.sv
// Saturating inter-word timeout counter; expired_o is high once LIMIT
// enabled cycles have elapsed since the last clear.
module spi_dc_timeout_cnt #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flag is registered from the next count so it matches cnt_q == LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LIMIT_C);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/spi_dc_frame_ctrl.sv
// Frame controller behind the SPI slave receiver: classifies words by D/C,
// expands write commands into register-bank strobes and flags framing errors.
module spi_dc_frame_ctrl #(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs_n,
  input  logic                dc,
  input  logic                rx_qvld,
  input  logic [DATA_LEN-1:0] rx_dout,
  output logic                rx_en,
  output logic                cmd_valid,
  output logic [DATA_LEN-1:0] cmd,
  output logic                reg_we,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_LEN-1:0] reg_wdata,
  output logic                busy,
  output logic                frame_err,
  output logic [1:0]          err_code
);

  import spi_dc_frame_ctrl_pkg::*;

  state_e              state_q, state_d;
  logic                rx_en_q, rx_en_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [DATA_LEN-1:0] cmd_q, cmd_d;
  logic                reg_we_q, reg_we_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_LEN-1:0] reg_wdata_q, reg_wdata_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic [REM_W-1:0]    remaining_q, remaining_d;

  logic take_cmd;
  logic word_accepted;
  logic tmo_expired;
  logic tmo_clr;

  // Counter only runs while parameters are pending; any other state holds it at 0.
  assign tmo_clr = word_accepted || (state_q != ST_WAIT_DATA);

  spi_dc_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (state_q == ST_WAIT_DATA),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = 1'b0;
    cmd_d         = cmd_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    addr_ptr_d    = addr_ptr_q;
    remaining_d   = remaining_q;
    take_cmd      = 1'b0;
    word_accepted = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n) state_d = ST_WAIT_CMD;
      end
      ST_WAIT_CMD: begin
        if (cs_n) begin
          state_d = ST_IDLE;
        end else if (rx_qvld) begin
          word_accepted = 1'b1;
          if (!dc) begin
            take_cmd = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_DC;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (cs_n) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_ABORT;
        end else if (rx_qvld) begin
          word_accepted = 1'b1;
          if (dc) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_ptr_q;
            reg_wdata_d = rx_dout;
            addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - REM_W'(1);
            if (remaining_q == REM_W'(1)) state_d = ST_WAIT_CMD;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_EARLY_CMD;
            take_cmd    = 1'b1;
          end
        end else if (tmo_expired) begin
          state_d     = ST_WAIT_CMD;
          frame_err_d = 1'b1;
          err_code_d  = ERR_ABORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Command decode is shared by WAIT_CMD and the early-command path in WAIT_DATA.
    if (take_cmd) begin
      cmd_d       = rx_dout;
      cmd_valid_d = 1'b1;
      if (rx_dout[CMD_WR_BIT]) begin
        addr_ptr_d  = rx_dout[ADDR_W-1:0];
        remaining_d = param_count(CMD_W'(rx_dout));
        state_d     = ST_WAIT_DATA;
      end else begin
        remaining_d = '0;
        state_d     = ST_WAIT_CMD;
      end
    end

    rx_en_d = (state_d != ST_IDLE);
    busy_d  = (state_d == ST_WAIT_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_en_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      addr_ptr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_en_q     <= rx_en_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
    end
  end

  assign rx_en     = rx_en_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule
